// File: rtl/lfsr_seq_checker.sv
// Tracks a received x^4+x^3+1 LFSR word stream: acquires lock after a run of
// correct successors, then flywheels the expected word and counts mismatches.
module lfsr_seq_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             err_clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);
    localparam logic [MATCH_W-1:0] LOCK_V   = MATCH_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]  UNLOCK_V = MISS_W'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state_p1, state_nxt;
    logic [3:0]          exp_p1, exp_nxt;
    logic [MATCH_W-1:0]  match_p1, match_nxt;
    logic [MISS_W-1:0]   miss_p1, miss_nxt;
    logic                hit;
    logic                cnt_mis;
    logic [CNT_W-1:0]    count_nxt;

    function automatic logic [3:0] nxt_word(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign hit = (in_data == exp_p1);

    // Stage p1: FSM state and tracking registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1 <= SEARCH;
            exp_p1   <= 4'b0000;
            match_p1 <= '0;
            miss_p1  <= '0;
        end else begin
            state_p1 <= state_nxt;
            exp_p1   <= exp_nxt;
            match_p1 <= match_nxt;
            miss_p1  <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p1;
        exp_nxt   = exp_p1;
        match_nxt = match_p1;
        miss_nxt  = miss_p1;
        if (in_valid) begin
            case (state_p1)
                SEARCH: begin
                    if (in_data != 4'b0000) begin
                        exp_nxt   = nxt_word(in_data);
                        match_nxt = '0;
                        state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        match_nxt = match_p1 + 1'b1;
                        exp_nxt   = nxt_word(in_data);
                        if (match_p1 + 1'b1 == LOCK_V) begin
                            state_nxt = LOCKED;
                            miss_nxt  = '0;
                        end
                    end else if (in_data != 4'b0000) begin
                        exp_nxt   = nxt_word(in_data);
                        match_nxt = '0;
                    end else begin
                        state_nxt = SEARCH;
                    end
                end
                LOCKED: begin
                    // Flywheel: the expected word advances regardless of the sample
                    exp_nxt = nxt_word(exp_p1);
                    if (hit) begin
                        miss_nxt = '0;
                    end else begin
                        miss_nxt = miss_p1 + 1'b1;
                        if (miss_p1 + 1'b1 == UNLOCK_V) begin
                            state_nxt = SEARCH;
                            miss_nxt  = '0;
                        end
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_comb begin
        cnt_mis   = in_valid && (state_p1 == LOCKED) && !hit;
        count_nxt = err_count;
        if (err_clr)
            count_nxt = cnt_mis ? CNT_W'(1) : '0;
        else if (cnt_mis)
            count_nxt = sat_inc(err_count);
    end

    // Stage p1: registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            locked    <= (state_nxt == LOCKED);
            err       <= cnt_mis;
            err_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed-vector bench for lfsr_seq_checker: a default-parameter instance
// driven from a vector table, and a CNT_W=2/UNLOCK_CNT=8 instance for saturation.
module tb_lfsr_seq_checker;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_valid, a_clr;
    logic [3:0] a_data;
    logic       a_locked, a_err;
    logic [7:0] a_count;

    logic       b_reset, b_valid, b_clr;
    logic [3:0] b_data;
    logic       b_locked, b_err;
    logic [1:0] b_count;

    lfsr_seq_checker dut_a (
        .clk(clk), .reset(a_reset), .in_valid(a_valid), .in_data(a_data),
        .err_clr(a_clr), .locked(a_locked), .err(a_err), .err_count(a_count)
    );

    lfsr_seq_checker #(.LOCK_CNT(4), .UNLOCK_CNT(8), .CNT_W(2)) dut_b (
        .clk(clk), .reset(b_reset), .in_valid(b_valid), .in_data(b_data),
        .err_clr(b_clr), .locked(b_locked), .err(b_err), .err_count(b_count)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic       clr;
        logic [3:0] d;
        logic       l;
        logic       e;
        logic [7:0] c;
    } vec_t;

    vec_t tbl[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic vec_t mk(input logic rst, input logic vld, input logic clr,
                                input logic [3:0] d, input logic l, input logic e,
                                input logic [7:0] c);
        vec_t v;
        v.rst = rst; v.vld = vld; v.clr = clr; v.d = d;
        v.l = l; v.e = e; v.c = c;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step_a(input vec_t v, input int idx);
        @(negedge clk);
        a_reset = v.rst; a_valid = v.vld; a_clr = v.clr; a_data = v.d;
        @(posedge clk);
        #1;
        chk("a_locked", idx, int'(a_locked), int'(v.l));
        chk("a_err", idx, int'(a_err), int'(v.e));
        chk("a_err_count", idx, int'(a_count), int'(v.c));
    endtask

    task automatic step_b(input vec_t v, input int idx);
        @(negedge clk);
        b_reset = v.rst; b_valid = v.vld; b_clr = v.clr; b_data = v.d;
        @(posedge clk);
        #1;
        chk("b_locked", idx, int'(b_locked), int'(v.l));
        chk("b_err", idx, int'(b_err), int'(v.e));
        chk("b_err_count", idx, int'(b_count), int'(v.c));
    endtask

    logic [3:0] wrap_seq [15];

    initial begin
        a_reset = 1'b1; a_valid = 1'b0; a_clr = 1'b0; a_data = 4'b0000;
        b_reset = 1'b1; b_valid = 1'b0; b_clr = 1'b0; b_data = 4'b0000;

        wrap_seq = '{4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111,
                     4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001,
                     4'b0011};

        // reset, reset overriding valid/clr, zeros in SEARCH
        tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0000, 0, 0, 0));
        // acquisition with valid gaps
        tbl.push_back(mk(0, 1, 0, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0100, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b1001, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0011, 1, 0, 0));
        // full period wrap while locked
        for (int i = 0; i < 15; i++)
            tbl.push_back(mk(0, 1, 0, wrap_seq[i], 1, 0, 0));
        // single error then resume
        tbl.push_back(mk(0, 1, 0, 4'b1111, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'b1101, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'b1010, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'b0101, 1, 0, 1));
        // clear alone, then three misses drop lock
        tbl.push_back(mk(0, 0, 1, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0000, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'b0001, 1, 1, 2));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 0, 1, 3));
        tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 3));
        // mismatches outside LOCKED: zero drops VERIFY, nonzero reseeds
        tbl.push_back(mk(0, 1, 0, 4'b0101, 0, 0, 3));
        tbl.push_back(mk(0, 1, 0, 4'b0000, 0, 0, 3));
        tbl.push_back(mk(0, 1, 0, 4'b1000, 0, 0, 3));
        tbl.push_back(mk(0, 1, 0, 4'b1111, 0, 0, 3));
        tbl.push_back(mk(0, 1, 0, 4'b1110, 0, 0, 3));
        tbl.push_back(mk(0, 1, 0, 4'b1100, 0, 0, 3));
        tbl.push_back(mk(0, 1, 0, 4'b1000, 0, 0, 3));
        tbl.push_back(mk(0, 1, 0, 4'b0001, 1, 0, 3));
        // clear with same-cycle mismatch, then reset mid-lock and restart
        tbl.push_back(mk(0, 1, 1, 4'b0111, 1, 1, 1));
        tbl.push_back(mk(1, 1, 0, 4'b0100, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0100, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b1001, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0011, 0, 0, 0));

        foreach (tbl[i]) step_a(tbl[i], i);
        a_valid = 1'b0;

        // saturation and clear on the narrow instance
        step_b(mk(1, 0, 0, 4'b0000, 0, 0, 0), 0);
        step_b(mk(0, 1, 0, 4'b0001, 0, 0, 0), 1);
        step_b(mk(0, 1, 0, 4'b0010, 0, 0, 0), 2);
        step_b(mk(0, 1, 0, 4'b0100, 0, 0, 0), 3);
        step_b(mk(0, 1, 0, 4'b1001, 0, 0, 0), 4);
        step_b(mk(0, 1, 0, 4'b0011, 1, 0, 0), 5);
        step_b(mk(0, 1, 0, 4'b0000, 1, 1, 1), 6);
        step_b(mk(0, 1, 0, 4'b0000, 1, 1, 2), 7);
        step_b(mk(0, 1, 0, 4'b0000, 1, 1, 3), 8);
        step_b(mk(0, 1, 0, 4'b0000, 1, 1, 3), 9);
        step_b(mk(0, 1, 0, 4'b0000, 1, 1, 3), 10);
        step_b(mk(0, 1, 1, 4'b0000, 1, 1, 1), 11);
        step_b(mk(0, 0, 1, 4'b0000, 1, 0, 0), 12);
        step_b(mk(0, 1, 0, 4'b0000, 1, 1, 1), 13);
        step_b(mk(0, 1, 0, 4'b0000, 0, 1, 2), 14);
        step_b(mk(0, 0, 0, 4'b0000, 0, 0, 2), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_checker.md
LFSR_SEQ_CHECKER -- requirements
Module: lfsr_seq_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive matching samples in VERIFY needed to declare lock.
REQ-002 Parameter UNLOCK_CNT, default 3: consecutive mismatching samples in LOCKED that drop lock.
REQ-003 Parameter CNT_W, default 8: width of err_count.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_data holds a sample this cycle.
REQ-007 in_data  input  4  received 4-bit LFSR state word.
REQ-008 err_clr  input  1  synchronous clear of err_count.
REQ-009 locked  output  1  high while FSM is in LOCKED.
REQ-010 err  output  1  one-cycle pulse per mismatching sample while LOCKED.
REQ-011 err_count  output  CNT_W  saturating count of LOCKED mismatches.

Function
REQ-012 Successor function nxt(s) SHALL be {s[2:0], s[3]^s[2]} (x^4+x^3+1, period 15, 0000 illegal).
REQ-013 Internal state SHALL be: FSM state, 4-bit expected word, match counter, miss counter.
REQ-014 All state changes SHALL occur only on cycles with in_valid=1; in_valid=0 holds all state (err_clr excepted).
REQ-015 SEARCH: nonzero sample -> expected=nxt(in_data), match_cnt=0, go VERIFY; sample 0000 -> stay SEARCH.
REQ-016 VERIFY, in_data==expected: match_cnt+1, expected=nxt(in_data); when match_cnt reaches LOCK_CNT go LOCKED, miss_cnt=0.
REQ-017 VERIFY, mismatch and in_data nonzero: reseed expected=nxt(in_data), match_cnt=0, stay VERIFY.
REQ-018 VERIFY, mismatch and in_data==0000: go SEARCH.
REQ-019 LOCKED, match: miss_cnt=0, expected=nxt(expected).
REQ-020 LOCKED, mismatch: flywheel, expected=nxt(expected), no reseed; err=1 next cycle; err_count+1; miss_cnt+1.
REQ-021 LOCKED, when miss_cnt reaches UNLOCK_CNT: go SEARCH; locked falls the following cycle.
REQ-022 Mismatches outside LOCKED SHALL NOT assert err or change err_count.
REQ-023 locked, err, err_count SHALL be registered: each updates the cycle after the sample that causes it.
REQ-024 err_count SHALL saturate at 2^CNT_W-1, never wrap.
REQ-025 err_clr with a same-cycle counted mismatch: err_count=1; err_clr alone: err_count=0.
REQ-026 err SHALL be high for exactly one cycle per counted mismatch; back-to-back mismatches keep err high continuously.

Reset
REQ-027 reset=1 at a clock edge SHALL give FSM=SEARCH, expected=0000, match_cnt=0, miss_cnt=0, locked=0, err=0, err_count=0.
REQ-028 reset SHALL override in_valid and err_clr in the same cycle.
REQ-029 reset mid-lock SHALL drop locked the next cycle; relock requires the full SEARCH/VERIFY sequence.

Verification
REQ-030 Clean lock: after reset, continuous valid samples 0001,0010,0100,1001,0011 -> locked=1 the cycle after 0011; err never high.
REQ-031 Wrap: continue the same stream through 15 samples past 1000 back to 0001 -> locked stays 1, err_count=0.
REQ-032 Single error while locked: expected 0110, send 1111, then resume with 1101 -> one err pulse, err_count=1, locked stays 1.
REQ-033 Loss of lock: while locked, send 3 consecutive wrong words -> err_count=3, locked=0 the cycle after the 3rd.
REQ-034 Zero/illegal input: send 0000 repeatedly in SEARCH -> stays SEARCH, locked=0, err_count=0; in_valid gaps mid-VERIFY do not break lock progress.
REQ-035 Saturation/clear: CNT_W=2, 5 locked mismatches with UNLOCK_CNT=8 -> err_count=3; err_clr with a mismatch in the same cycle -> err_count=1.
